// File: rtl/rom_arbiter.sv
// rom_arbiter: two-port read arbiter in front of a shared, single-ported ROM.
//
// Port 0 is the CPU fetch side and port 1 is the debug/loader side. At most one
// request is accepted per cycle. The grant is decided combinationally in the
// request cycle. The ROM returns registered data one cycle later. The response
// is steered back to the owner recorded at grant time.
//
// Arbitration modes, selected by FIXED_PRI:
//   0 : round-robin. On contention, the port not granted most recently wins.
//   1 : fixed priority to port 0, with a starvation guard. Once port 1 has been
//       denied STARVE_LIMIT consecutive cycles, it is forced through.
//       STARVE_LIMIT must lie in 1..15 because the counter is 4 bits wide.
//
// Ports:
//   HCLK                   single clock, all state on the rising edge
//   HRESETn                asynchronous active-low reset; also masks grants
//   m0_req / m1_req        read request; held with the address until the grant
//   m0_addr / m1_addr      13-bit word address
//   m0_gnt / m1_gnt        request accepted this cycle
//   m0_rvalid / m1_rvalid  read data valid, one cycle after the grant
//   m0_rdata / m1_rdata    read data; zero whenever rvalid is low
//   rom_cs                 ROM select (any grant)
//   rom_addr               granted address, zero when idle
//   rom_rdata              ROM registered read data
module rom_arbiter #(
  parameter int unsigned FIXED_PRI    = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,

  input  logic        m0_req,
  input  logic [12:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic [12:0] m1_addr,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic        rom_cs,
  output logic [12:0] rom_addr,
  input  logic [31:0] rom_rdata
);

  localparam bit         FixedMode   = (FIXED_PRI != 0);
  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  // Arbitration and response-tracking state.
  logic       last_grant_q, last_grant_d;   // 1 = port 1 was granted most recently
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       owner_vld_q,  owner_vld_d;
  logic       owner_id_q,   owner_id_d;

  // Winner on contention: 1 selects port 1.
  logic       pick_m1;

  always_comb begin
    pick_m1 = 1'b0;
    if (FixedMode) begin
      pick_m1 = (starve_cnt_q == StarveLimit);
    end else begin
      pick_m1 = ~last_grant_q;
    end
  end

  // Grant decision. Reset masks the grants combinationally. This keeps a
  // requester from being told its access was accepted while the response
  // path is held cleared.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (HRESETn) begin
      if (m0_req && m1_req) begin
        m0_gnt = ~pick_m1;
        m1_gnt = pick_m1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    rom_cs   = m0_gnt | m1_gnt;
    rom_addr = 13'h0;
    if (m1_gnt) begin
      rom_addr = m1_addr;
    end else if (m0_gnt) begin
      rom_addr = m0_addr;
    end
  end

  // Next-state logic.
  always_comb begin
    last_grant_d = last_grant_q;
    if (rom_cs) begin
      last_grant_d = m1_gnt;
    end

    // Count consecutive denials of port 1. Any gap in its request restarts
    // the count, so only an unbroken wait earns a forced grant.
    starve_cnt_d = 4'h0;
    if (FixedMode && m1_req && !m1_gnt) begin
      if (starve_cnt_q < StarveLimit) begin
        starve_cnt_d = starve_cnt_q + 4'h1;
      end else begin
        starve_cnt_d = starve_cnt_q;
      end
    end

    owner_vld_d = rom_cs;
    owner_id_d  = m1_gnt;
  end

  // After reset, last_grant points at port 1, so port 0 wins the first
  // contention in round-robin mode.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last_grant_q <= 1'b1;
      starve_cnt_q <= 4'h0;
      owner_vld_q  <= 1'b0;
      owner_id_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      owner_vld_q  <= owner_vld_d;
      owner_id_q   <= owner_id_d;
    end
  end

  // Response steering. The ROM data lines are only forwarded to the owner of
  // the access completing this cycle.
  always_comb begin
    m0_rvalid = owner_vld_q & ~owner_id_q;
    m1_rvalid = owner_vld_q &  owner_id_q;
    m0_rdata  = m0_rvalid ? rom_rdata : 32'h0;
    m1_rdata  = m1_rvalid ? rom_rdata : 32'h0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter. It builds two instances on shared request inputs:
// one in round-robin mode and one in fixed-priority mode. Each instance has its
// own registered ROM model. `sel` chooses which instance is being checked.
// When a grant is expected, the matching response is pushed to a queue. It is
// popped and compared in the following cycle.
module tb_rom_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        m0_req, m1_req;
  logic [12:0] m0_addr, m1_addr;

  always #5 HCLK = ~HCLK;

  // Round-robin instance.
  logic        rr_m0_gnt, rr_m0_rvalid, rr_m1_gnt, rr_m1_rvalid, rr_rom_cs;
  logic [31:0] rr_m0_rdata, rr_m1_rdata, rr_rom_rdata;
  logic [12:0] rr_rom_addr;

  // Fixed-priority instance.
  logic        fx_m0_gnt, fx_m0_rvalid, fx_m1_gnt, fx_m1_rvalid, fx_rom_cs;
  logic [31:0] fx_m0_rdata, fx_m1_rdata, fx_rom_rdata;
  logic [12:0] fx_rom_addr;

  rom_arbiter #(.FIXED_PRI(0), .STARVE_LIMIT(4)) dut_rr (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_gnt    (rr_m0_gnt),
    .m0_rvalid (rr_m0_rvalid),
    .m0_rdata  (rr_m0_rdata),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_gnt    (rr_m1_gnt),
    .m1_rvalid (rr_m1_rvalid),
    .m1_rdata  (rr_m1_rdata),
    .rom_cs    (rr_rom_cs),
    .rom_addr  (rr_rom_addr),
    .rom_rdata (rr_rom_rdata)
  );

  rom_arbiter #(.FIXED_PRI(1), .STARVE_LIMIT(4)) dut_fx (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .m0_req    (m0_req),
    .m0_addr   (m0_addr),
    .m0_gnt    (fx_m0_gnt),
    .m0_rvalid (fx_m0_rvalid),
    .m0_rdata  (fx_m0_rdata),
    .m1_req    (m1_req),
    .m1_addr   (m1_addr),
    .m1_gnt    (fx_m1_gnt),
    .m1_rvalid (fx_m1_rvalid),
    .m1_rdata  (fx_m1_rdata),
    .rom_cs    (fx_rom_cs),
    .rom_addr  (fx_rom_addr),
    .rom_rdata (fx_rom_rdata)
  );

  // ROM contents: each word is a recognisable function of its address.
  function automatic logic [31:0] rom_word(input logic [12:0] a);
    return {3'b101, a, 3'b011, ~a};
  endfunction

  always_ff @(posedge HCLK) begin
    if (rr_rom_cs) rr_rom_rdata <= rom_word(rr_rom_addr);
    if (fx_rom_cs) fx_rom_rdata <= rom_word(fx_rom_addr);
  end

  // Observed outputs of the instance under check.
  logic        sel;
  logic        o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_rom_cs;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic [12:0] o_rom_addr;

  assign o_m0_gnt    = sel ? fx_m0_gnt    : rr_m0_gnt;
  assign o_m1_gnt    = sel ? fx_m1_gnt    : rr_m1_gnt;
  assign o_m0_rvalid = sel ? fx_m0_rvalid : rr_m0_rvalid;
  assign o_m1_rvalid = sel ? fx_m1_rvalid : rr_m1_rvalid;
  assign o_m0_rdata  = sel ? fx_m0_rdata  : rr_m0_rdata;
  assign o_m1_rdata  = sel ? fx_m1_rdata  : rr_m1_rdata;
  assign o_rom_cs    = sel ? fx_rom_cs    : rr_rom_cs;
  assign o_rom_addr  = sel ? fx_rom_addr  : rr_rom_addr;

  int checks = 0;
  int errors = 0;

  // Expected responses: bit 32 is the port, bits 31:0 are the data.
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag);
    logic [32:0] e;
    logic        v0, v1;
    logic [31:0] d0, d1;
    v0 = 1'b0; v1 = 1'b0; d0 = 32'h0; d1 = 32'h0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      v0 = ~e[32];
      v1 = e[32];
      if (e[32]) d1 = e[31:0];
      else       d0 = e[31:0];
    end
    chk({tag, "_m0_rvalid"}, 32'(o_m0_rvalid), 32'(v0));
    chk({tag, "_m1_rvalid"}, 32'(o_m1_rvalid), 32'(v1));
    chk({tag, "_m0_rdata"},  o_m0_rdata, d0);
    chk({tag, "_m1_rdata"},  o_m1_rdata, d1);
  endtask

  // One bus cycle. First check the response to the previous cycle. Then drive
  // the requests, check the grant, and queue the expected response.
  task automatic step(input string tag, input logic r0, input logic [12:0] a0,
                      input logic r1, input logic [12:0] a1,
                      input logic e0, input logic e1);
    logic [12:0] ea;
    @(negedge HCLK);
    check_resp(tag);
    m0_req  = r0;
    m0_addr = a0;
    m1_req  = r1;
    m1_addr = a1;
    #1;
    ea = e1 ? a1 : (e0 ? a0 : 13'h0);
    chk({tag, "_m0_gnt"},   32'(o_m0_gnt),   32'(e0));
    chk({tag, "_m1_gnt"},   32'(o_m1_gnt),   32'(e1));
    chk({tag, "_rom_cs"},   32'(o_rom_cs),   32'(e0 | e1));
    chk({tag, "_rom_addr"}, 32'(o_rom_addr), 32'(ea));
    if (e0)      exp_q.push_back({1'b0, rom_word(a0)});
    else if (e1) exp_q.push_back({1'b1, rom_word(a1)});
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    m0_req = 1'b0; m1_req = 1'b0; m0_addr = 13'h0; m1_addr = 13'h0;
    HRESETn = 1'b0;
    exp_q.delete();
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    sel     = 1'b0;
    HRESETn = 1'b0;
    m0_req  = 1'b1; m0_addr = 13'h0AA;
    m1_req  = 1'b1; m1_addr = 13'h0BB;
    repeat (2) @(negedge HCLK);
    #1;
    // Requests during reset must not leak through on either instance.
    chk("rst_rr_gnt0",   32'(rr_m0_gnt),    32'h0);
    chk("rst_rr_gnt1",   32'(rr_m1_gnt),    32'h0);
    chk("rst_rr_cs",     32'(rr_rom_cs),    32'h0);
    chk("rst_rr_addr",   32'(rr_rom_addr),  32'h0);
    chk("rst_rr_rv0",    32'(rr_m0_rvalid), 32'h0);
    chk("rst_rr_rv1",    32'(rr_m1_rvalid), 32'h0);
    chk("rst_rr_rdata0", rr_m0_rdata,       32'h0);
    chk("rst_fx_gnt0",   32'(fx_m0_gnt),    32'h0);
    chk("rst_fx_gnt1",   32'(fx_m1_gnt),    32'h0);
    chk("rst_fx_cs",     32'(fx_rom_cs),    32'h0);
    chk("rst_fx_rdata1", fx_m1_rdata,       32'h0);
    m0_req = 1'b0; m1_req = 1'b0;
    HRESETn = 1'b1;

    // Single read on port 0.
    step("single", 1'b1, 13'h0010, 1'b0, 13'h0, 1'b1, 1'b0);
    step("single_rsp", 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0);
    step("single_m1", 1'b0, 13'h0, 1'b1, 13'h1ABC, 1'b0, 1'b1);
    step("single_m1_rsp", 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0);

    // Round-robin contention: alternation starts with port 0 after reset.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step("rr", 1'b1, 13'h0001, 1'b1, 13'h0002, (i % 2) == 0, (i % 2) == 1);
    end
    step("rr_flush", 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0);

    // Ten idle cycles.
    for (int i = 0; i < 10; i++) begin
      step("idle", 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0);
    end

    // Reset pulse right after a port 1 grant drops the pending response.
    do_reset();
    step("rst_pend", 1'b0, 13'h0, 1'b1, 13'h0055, 1'b0, 1'b1);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    exp_q.delete();
    @(negedge HCLK);
    m0_req = 1'b1; m0_addr = 13'h0020;
    m1_req = 1'b1; m1_addr = 13'h0021;
    #1;
    chk("rst_low_gnt0",    32'(o_m0_gnt),    32'h0);
    chk("rst_low_gnt1",    32'(o_m1_gnt),    32'h0);
    chk("rst_low_cs",      32'(o_rom_cs),    32'h0);
    chk("rst_low_addr",    32'(o_rom_addr),  32'h0);
    chk("rst_low_m1_rv",   32'(o_m1_rvalid), 32'h0);
    chk("rst_low_m1_data", o_m1_rdata,       32'h0);
    m0_req = 1'b0; m1_req = 1'b0;
    HRESETn = 1'b1;
    step("rst_rel", 1'b1, 13'h0020, 1'b1, 13'h0021, 1'b1, 1'b0);
    step("rst_rel_rsp", 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0);

    // Fixed priority: port 1 is forced through after four denials.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step("fx_pri", 1'b1, 13'h0003, 1'b1, 13'h0004, 1'b1, 1'b0);
    end
    step("fx_force", 1'b1, 13'h0003, 1'b1, 13'h0004, 1'b0, 1'b1);
    step("fx_after", 1'b1, 13'h0003, 1'b1, 13'h0004, 1'b1, 1'b0);
    step("fx_flush", 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0);

    // Dropping port 1's request restarts the starvation count.
    do_reset();
    step("fx_den0", 1'b1, 13'h0100, 1'b1, 13'h0200, 1'b1, 1'b0);
    step("fx_den1", 1'b1, 13'h0101, 1'b1, 13'h0200, 1'b1, 1'b0);
    step("fx_drop", 1'b1, 13'h0102, 1'b0, 13'h0200, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("fx_reden", 1'b1, 13'(13'h0110 + i), 1'b1, 13'h0200, 1'b1, 1'b0);
    end
    step("fx_reforce", 1'b1, 13'h0120, 1'b1, 13'h0200, 1'b0, 1'b1);
    step("fx_lone_m1", 1'b0, 13'h0, 1'b1, 13'h1FFF, 1'b0, 1'b1);
    step("fx_end", 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0);
    step("fx_end2", 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter: FIXED_PRI, default 0, 0 = round-robin arbitration, 1 = fixed priority to port 0 with starvation guard.
REQ-002 SHALL have parameter: STARVE_LIMIT, default 4, consecutive denied cycles of port 1 before forced grant (FIXED_PRI=1 only); legal range 1..15.
REQ-003 SHALL have port: HCLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: m0_req  input  1  port 0 read request (CPU fetch side).
REQ-006 SHALL have port: m0_addr  input  13  port 0 word address.
REQ-007 SHALL have port: m0_gnt  output  1  port 0 request accepted this cycle.
REQ-008 SHALL have port: m0_rvalid  output  1  port 0 read data valid.
REQ-009 SHALL have port: m0_rdata  output  32  port 0 read data.
REQ-010 SHALL have ports: m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata, with the same directions, widths and meanings for port 1 (debug/loader side).
REQ-011 SHALL have port: rom_cs  output  1  ROM select to the shared ROM.
REQ-012 SHALL have port: rom_addr  output  13  ROM word address.
REQ-013 SHALL have port: rom_rdata  input  32  ROM registered read data, valid one HCLK after rom_cs=1.

Function
REQ-014 SHALL decide the grant combinationally in the request cycle; at most one of m0_gnt/m1_gnt high in any cycle.
REQ-015 SHALL drive rom_cs = m0_gnt | m1_gnt, and rom_addr = granted port's address; rom_addr = 0 when no grant.
REQ-016 SHALL assert mX_gnt only when mX_req=1; a requester holds req and addr until gnt is seen.
REQ-017 SHALL, with a single requester, grant it in the same cycle regardless of mode.
REQ-018 SHALL, in round-robin mode with both requesting, grant the port not granted most recently; last_grant register updates only on a grant cycle.
REQ-019 SHALL, in fixed mode with both requesting, grant port 0 unless starve_cnt == STARVE_LIMIT, in which case grant port 1.
REQ-020 SHALL keep a 4-bit starve_cnt: +1 when m1_req=1 and m1_gnt=0, saturating at STARVE_LIMIT; cleared to 0 when m1_gnt=1 or m1_req=0; held at 0 when FIXED_PRI=0.
REQ-021 SHALL register the grant owner (owner_vld, owner_id) each cycle; owner_vld=0 if no grant.
REQ-022 SHALL assert mX_rvalid exactly one cycle after mX_gnt, for one cycle per grant; read latency = 1 cycle.
REQ-023 SHALL route mX_rdata = rom_rdata when mX_rvalid=1, else 32'h0.
REQ-024 SHALL support back-to-back grants every cycle (one access per cycle throughput), including alternating ports; response order equals grant order.

Reset
REQ-025 SHALL, while HRESETn=0, force m0_gnt=m1_gnt=0, rom_cs=0, rom_addr=0 regardless of requests.
REQ-026 SHALL asynchronously reset: owner_vld=0, owner_id=0, last_grant=1 (port 0 wins first contention), starve_cnt=0; hence rvalid=0, rdata=0 for both ports.
REQ-027 SHALL drop any response pending at reset assertion; no rvalid in the first cycle after reset release.

Verification
REQ-028 SHALL cover: single read, m0_req=1, m0_addr=13'h0010 -> m0_gnt=1, rom_cs=1, rom_addr=0x0010 same cycle; next cycle m0_rvalid=1, m0_rdata=ROM word 0x10, m1_rvalid=0.
REQ-029 SHALL cover: round-robin, both req held 6 cycles, m0_addr=0x1, m1_addr=0x2 -> grants m0,m1,m0,m1,m0,m1; rvalids follow one cycle later with matching data.
REQ-030 SHALL cover: FIXED_PRI=1, STARVE_LIMIT=4, both req held -> m0 granted cycles 0-3, m1 granted cycle 4, starve_cnt back to 0, m0 granted cycle 5.
REQ-031 SHALL cover: FIXED_PRI=1, m1_req dropped after 2 denied cycles then reasserted -> starve_cnt restarts at 0; m1 forced grant only after 4 further denied cycles.
REQ-032 SHALL cover: HRESETn pulsed low one cycle after m1_gnt -> m1_rvalid=0 during and after reset, no gnt while low; after release m0 wins first contention.
REQ-033 SHALL cover: no requests for 10 cycles -> rom_cs=0, rom_addr=0, all rvalid=0, all rdata=0.
